tg_sequencer: RTL and testbench

Command sequencer for the traffic generator `tg`. It queues test-phase commands (mode plus packet/flit shape), applies them one at a time to the generator's configuration inputs, and counts completed packets on the generator's AXI Stream output. It parks the generator in mode 0 for a programmable gap between phases. It sits between the host/config logic and `tg`, so a testbench or controller can load a whole traffic schedule up front.

---
 rtl/tg_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_tg_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tg_sequencer.sv
// Command sequencer for the tg traffic generator: queues test phases, drives the
// generator's configuration one phase at a time and counts TLAST handshakes to detect completion.
module tg_sequencer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [5:0]             cmd_mode,
  input  logic [15:0]            cmd_num_packets,
  input  logic [15:0]            cmd_num_flits,
  input  logic [7:0]             cmd_last_flit_bytes,
  input  logic [15:0]            cmd_M,
  input  logic [15:0]            cmd_N,
  input  logic                   abort,
  output logic [31:0]            mode,
  output logic [31:0]            num_packets,
  output logic [31:0]            num_flits,
  output logic [31:0]            last_flit_bytes,
  output logic [31:0]            M,
  output logic [31:0]            N,
  input  logic                   mon_tvalid,
  input  logic                   mon_tready,
  input  logic                   mon_tlast,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [15:0]            pkt_count,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 78;
  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [AW:0] PTR_ONE = 1;

  // Command storage
  logic [EW-1:0] mem [0:DEPTH-1];
  logic [EW-1:0] rd_data_q;
  logic [EW-1:0] cmd_word;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Sequencer state
  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          pend_q, pend_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          beat;

  // Configuration registers
  logic [5:0]    mode_q, mode_d;
  logic [15:0]   np_q, np_d;
  logic [15:0]   nf_q, nf_d;
  logic [7:0]    lfb_q, lfb_d;
  logic [15:0]   m_q, m_d;
  logic [15:0]   n_q, n_d;

  // Fields of the popped entry
  logic [5:0]    rd_mode;
  logic [15:0]   rd_np;
  logic [15:0]   rd_nf;
  logic [7:0]    rd_lfb;
  logic [15:0]   rd_m;
  logic [15:0]   rd_n;

  assign cmd_word = {cmd_mode, cmd_num_packets, cmd_num_flits,
                     cmd_last_flit_bytes, cmd_M, cmd_N};

  assign rd_mode = rd_data_q[77:72];
  assign rd_np   = rd_data_q[71:56];
  assign rd_nf   = rd_data_q[55:40];
  assign rd_lfb  = rd_data_q[39:32];
  assign rd_m    = rd_data_q[31:16];
  assign rd_n    = rd_data_q[15:0];

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign full       = (fifo_count == (AW+1)'(DEPTH));
  assign empty      = (fifo_count == '0);
  assign cmd_ready  = rst && !full && !abort;
  assign push       = cmd_valid && cmd_ready;
  assign beat       = mon_tvalid && mon_tready && mon_tlast;

  // Storage array kept free of reset so it maps onto block RAM with a registered read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= cmd_word;
    end
    if (pop) begin
      rd_data_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  // A pop issues one cycle before the state can use the data (registered read), so the
  // entry is prefetched on the last cycle of RUN/GAP to keep back-to-back phases tight.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pend_d    = pend_q;
    pkt_cnt_d = pkt_cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    pop       = 1'b0;
    mode_d    = mode_q;
    np_d      = np_q;
    nf_d      = nf_q;
    lfb_d     = lfb_q;
    m_d       = m_q;
    n_d       = n_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (abort) begin
      state_d   = ST_IDLE;
      pend_d    = 1'b0;
      aborted_d = 1'b1;
      mode_d    = '0;
      np_d      = '0;
      nf_d      = '0;
      lfb_d     = '0;
      m_d       = '0;
      n_d       = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_q) begin
            pend_d = 1'b0;
            if (rd_np != 16'd0) begin
              mode_d    = rd_mode;
              np_d      = rd_np;
              nf_d      = rd_nf;
              lfb_d     = rd_lfb;
              m_d       = rd_m;
              n_d       = rd_n;
              pkt_cnt_d = 16'd0;
              state_d   = ST_RUN;
            end else begin
              done_d = 1'b1;
            end
          end else if (!empty) begin
            pop = 1'b1;
          end
        end
        ST_RUN: begin
          if (beat) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            if (pkt_cnt_q == np_q - 16'd1) begin
              done_d = 1'b1;
              mode_d = '0;
              np_d   = '0;
              nf_d   = '0;
              lfb_d  = '0;
              m_d    = '0;
              n_d    = '0;
              if (GAP == 0) begin
                state_d = ST_IDLE;
                pop     = !empty;
              end else begin
                state_d   = ST_GAP;
                gap_cnt_d = GW'(GAP);
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GW'(1)) begin
            state_d = ST_IDLE;
            pop     = !empty;
          end else begin
            gap_cnt_d = gap_cnt_q - GW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      pend_q    <= 1'b0;
      pkt_cnt_q <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      mode_q    <= '0;
      np_q      <= '0;
      nf_q      <= '0;
      lfb_q     <= '0;
      m_q       <= '0;
      n_q       <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      pend_q    <= pend_d;
      pkt_cnt_q <= pkt_cnt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      mode_q    <= mode_d;
      np_q      <= np_d;
      nf_q      <= nf_d;
      lfb_q     <= lfb_d;
      m_q       <= m_d;
      n_q       <= n_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign mode            = {26'd0, mode_q};
  assign num_packets     = {16'd0, np_q};
  assign num_flits       = {16'd0, nf_q};
  assign last_flit_bytes = {24'd0, lfb_q};
  assign M               = {16'd0, m_q};
  assign N               = {16'd0, n_q};
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign pkt_count       = pkt_cnt_q;

endmodule

// File: tb/tb_tg_sequencer.sv
// Directed bench for tg_sequencer: one GAP=4 instance and one GAP=0 instance sharing
// command fields, monitor taps, abort and reset; each has its own cmd_valid.
module tb_tg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_valid_g0;
  logic        abort;
  logic        mon_tvalid, mon_tready, mon_tlast;
  logic [5:0]  cmd_mode;
  logic [15:0] cmd_num_packets, cmd_num_flits, cmd_M, cmd_N;
  logic [7:0]  cmd_last_flit_bytes;

  logic        cmd_ready, busy, done, aborted;
  logic [31:0] mode, num_packets, num_flits, last_flit_bytes, M, N;
  logic [15:0] pkt_count;
  logic [2:0]  fifo_count;

  logic        cmd_ready_g0, busy_g0, done_g0, aborted_g0;
  logic [31:0] mode_g0, num_packets_g0, num_flits_g0, last_flit_bytes_g0, M_g0, N_g0;
  logic [15:0] pkt_count_g0;
  logic [2:0]  fifo_count_g0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tg_sequencer #(.DEPTH(4), .GAP(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_num_packets(cmd_num_packets), .cmd_num_flits(cmd_num_flits),
    .cmd_last_flit_bytes(cmd_last_flit_bytes), .cmd_M(cmd_M), .cmd_N(cmd_N), .abort(abort),
    .mode(mode), .num_packets(num_packets), .num_flits(num_flits),
    .last_flit_bytes(last_flit_bytes), .M(M), .N(N),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .busy(busy), .done(done), .aborted(aborted), .pkt_count(pkt_count), .fifo_count(fifo_count)
  );

  tg_sequencer #(.DEPTH(4), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_g0), .cmd_ready(cmd_ready_g0),
    .cmd_mode(cmd_mode), .cmd_num_packets(cmd_num_packets), .cmd_num_flits(cmd_num_flits),
    .cmd_last_flit_bytes(cmd_last_flit_bytes), .cmd_M(cmd_M), .cmd_N(cmd_N), .abort(abort),
    .mode(mode_g0), .num_packets(num_packets_g0), .num_flits(num_flits_g0),
    .last_flit_bytes(last_flit_bytes_g0), .M(M_g0), .N(N_g0),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .busy(busy_g0), .done(done_g0), .aborted(aborted_g0), .pkt_count(pkt_count_g0),
    .fifo_count(fifo_count_g0)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic [5:0] md, input logic [15:0] np, input logic [15:0] nf,
                         input logic [7:0] lfb, input logic [15:0] m, input logic [15:0] n);
    cmd_mode = md; cmd_num_packets = np; cmd_num_flits = nf;
    cmd_last_flit_bytes = lfb; cmd_M = m; cmd_N = n;
  endtask

  task automatic push(input logic [5:0] md, input logic [15:0] np);
    set_cmd(md, np, 16'd4, 8'd8, 16'd5, 16'd6);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    $display("push dut mode=%0d num_packets=%0d", md, np);
  endtask

  task automatic push_g0(input logic [5:0] md, input logic [15:0] np);
    set_cmd(md, np, 16'd1, 8'd2, 16'd3, 16'd4);
    cmd_valid_g0 = 1'b1;
    tick();
    cmd_valid_g0 = 1'b0;
    $display("push dut_g0 mode=%0d num_packets=%0d", md, np);
  endtask

  task automatic beat();
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
    tick();
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_idle_timeout: busy=%b want 0", tag, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_cmd(6'd1, 16'd1, 16'd1, 8'd1, 16'd1, 16'd1);
    cmd_valid = 1'b1;
    tick(); tick();
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rst_fifo_count: got %0d want 0", fifo_count); end
    n_cmp++; if ({mode, num_packets, num_flits, last_flit_bytes, M, N} !== 192'd0) begin n_err++; $display("FAIL rst_config: got nonzero want 0"); end
    n_cmp++; if ({busy, done, aborted} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {busy, done, aborted}); end
    n_cmp++; if (pkt_count !== 16'd0) begin n_err++; $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); end
    n_cmp++; if (fifo_count_g0 !== 3'd0 || busy_g0 !== 1'b0) begin n_err++; $display("FAIL rst_g0: got fifo=%0d busy=%b want 0/0", fifo_count_g0, busy_g0); end
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
    tick();
    $display("test_reset complete");
  endtask

  task automatic test_single();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", cmd_ready); end
    push(6'd3, 16'd2);
    n_cmp++; if (fifo_count !== 3'd1 || mode !== 32'd0 || busy !== 1'b0) begin n_err++; $display("FAIL single_t0: got fifo=%0d mode=%0d busy=%b want 1/0/0", fifo_count, mode, busy); end
    tick();
    n_cmp++; if (fifo_count !== 3'd0 || mode !== 32'd0 || busy !== 1'b0) begin n_err++; $display("FAIL single_t1: got fifo=%0d mode=%0d busy=%b want 0/0/0", fifo_count, mode, busy); end
    tick();
    n_cmp++; if (mode !== 32'd3 || num_packets !== 32'd2 || num_flits !== 32'd4) begin n_err++; $display("FAIL single_cfg_a: got %0d/%0d/%0d want 3/2/4", mode, num_packets, num_flits); end
    n_cmp++; if (last_flit_bytes !== 32'd8 || M !== 32'd5 || N !== 32'd6) begin n_err++; $display("FAIL single_cfg_b: got %0d/%0d/%0d want 8/5/6", last_flit_bytes, M, N); end
    n_cmp++; if (busy !== 1'b1 || pkt_count !== 16'd0) begin n_err++; $display("FAIL single_run: got busy=%b pkt=%0d want 1/0", busy, pkt_count); end
    beat();
    n_cmp++; if (pkt_count !== 16'd1 || done !== 1'b0 || mode !== 32'd3) begin n_err++; $display("FAIL single_beat1: got pkt=%0d done=%b mode=%0d want 1/0/3", pkt_count, done, mode); end
    tick();
    n_cmp++; if (pkt_count !== 16'd1) begin n_err++; $display("FAIL single_hold: got pkt=%0d want 1", pkt_count); end
    beat();
    n_cmp++; if (pkt_count !== 16'd2 || done !== 1'b1) begin n_err++; $display("FAIL single_done: got pkt=%0d done=%b want 2/1", pkt_count, done); end
    n_cmp++; if (mode !== 32'd0 || num_packets !== 32'd0 || busy !== 1'b1) begin n_err++; $display("FAIL single_gap_entry: got mode=%0d np=%0d busy=%b want 0/0/1", mode, num_packets, busy); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL single_gap%0d: got busy=%b done=%b want 1/0", i, busy, done); end
    end
    tick();
    n_cmp++; if (busy !== 1'b0 || pkt_count !== 16'd2) begin n_err++; $display("FAIL single_gap_exit: got busy=%b pkt=%0d want 0/2", busy, pkt_count); end
    $display("test_single complete");
  endtask

  task automatic test_ignored_beats_and_abort();
    push(6'd4, 16'd3);
    tick(); tick();
    n_cmp++; if (mode !== 32'd4) begin n_err++; $display("FAIL ign_load: got mode=%0d want 4", mode); end
    mon_tvalid = 1'b1; mon_tready = 1'b0; mon_tlast = 1'b1; tick();
    n_cmp++; if (pkt_count !== 16'd0) begin n_err++; $display("FAIL ign_noready: got pkt=%0d want 0", pkt_count); end
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0; tick();
    n_cmp++; if (pkt_count !== 16'd0) begin n_err++; $display("FAIL ign_nolast: got pkt=%0d want 0", pkt_count); end
    mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tlast = 1'b1; tick();
    n_cmp++; if (pkt_count !== 16'd0) begin n_err++; $display("FAIL ign_novalid: got pkt=%0d want 0", pkt_count); end
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    beat();
    n_cmp++; if (pkt_count !== 16'd1 || done !== 1'b0) begin n_err++; $display("FAIL ign_real: got pkt=%0d done=%b want 1/0", pkt_count, done); end
    push(6'd5, 16'd1);
    n_cmp++; if (fifo_count !== 3'd1 || mode !== 32'd4) begin n_err++; $display("FAIL abort_prequeue: got fifo=%0d mode=%0d want 1/4", fifo_count, mode); end
    abort = 1'b1;
    set_cmd(6'd6, 16'd1, 16'd1, 8'd1, 16'd1, 16'd1);
    cmd_valid = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %b want 0", cmd_ready); end
    tick();
    n_cmp++; if (mode !== 32'd0 || fifo_count !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_state: got mode=%0d fifo=%0d busy=%b want 0/0/0", mode, fifo_count, busy); end
    n_cmp++; if (aborted !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL abort_pulse: got aborted=%b done=%b want 1/0", aborted, done); end
    abort = 1'b0;
    cmd_valid = 1'b0;
    tick();
    n_cmp++; if (aborted !== 1'b0 || done !== 1'b0 || fifo_count !== 3'd0) begin n_err++; $display("FAIL abort_after: got aborted=%b done=%b fifo=%0d want 0/0/0", aborted, done, fifo_count); end
    push(6'd7, 16'd1);
    tick(); tick();
    n_cmp++; if (mode !== 32'd7 || pkt_count !== 16'd0 || busy !== 1'b1) begin n_err++; $display("FAIL abort_repush: got mode=%0d pkt=%0d busy=%b want 7/0/1", mode, pkt_count, busy); end
    beat();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL abort_repush_done: got %b want 1", done); end
    wait_idle("abort_repush");
    $display("test_ignored_beats_and_abort complete");
  endtask

  task automatic test_queue_full();
    push(6'd1, 16'd1);
    tick(); tick();
    n_cmp++; if (mode !== 32'd1 || busy !== 1'b1) begin n_err++; $display("FAIL full_load: got mode=%0d busy=%b want 1/1", mode, busy); end
    for (int i = 0; i < 4; i++) push(6'(2 + i), 16'd1);
    #1;
    n_cmp++; if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_count: got fifo=%0d ready=%b want 4/0", fifo_count, cmd_ready); end
    set_cmd(6'd6, 16'd1, 16'd4, 8'd8, 16'd5, 16'd6);
    cmd_valid = 1'b1;
    beat();
    n_cmp++; if (done !== 1'b1 || fifo_count !== 3'd4 || mode !== 32'd0) begin n_err++; $display("FAIL full_done: got done=%b fifo=%0d mode=%0d want 1/4/0", done, fifo_count, mode); end
    tick(); tick(); tick();
    n_cmp++; if (fifo_count !== 3'd4 || busy !== 1'b1) begin n_err++; $display("FAIL full_gap_hold: got fifo=%0d busy=%b want 4/1", fifo_count, busy); end
    tick();
    n_cmp++; if (fifo_count !== 3'd3 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL full_pop: got fifo=%0d ready=%b busy=%b want 3/1/0", fifo_count, cmd_ready, busy); end
    tick();
    cmd_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd4 || mode !== 32'd2 || busy !== 1'b1) begin n_err++; $display("FAIL full_fifth: got fifo=%0d mode=%0d busy=%b want 4/2/1", fifo_count, mode, busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (aborted !== 1'b1 || fifo_count !== 3'd0) begin n_err++; $display("FAIL full_flush: got aborted=%b fifo=%0d want 1/0", aborted, fifo_count); end
    tick();
    $display("test_queue_full complete");
  endtask

  task automatic test_zero_packet();
    push(6'd9, 16'd0);
    push(6'd10, 16'd1);
    n_cmp++; if (fifo_count !== 3'd1 || mode !== 32'd0 || done !== 1'b0) begin n_err++; $display("FAIL zero_t1: got fifo=%0d mode=%0d done=%b want 1/0/0", fifo_count, mode, done); end
    tick();
    n_cmp++; if (done !== 1'b1 || mode !== 32'd0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_done: got done=%b mode=%0d busy=%b want 1/0/0", done, mode, busy); end
    tick();
    n_cmp++; if (done !== 1'b0 || mode !== 32'd0 || fifo_count !== 3'd0) begin n_err++; $display("FAIL zero_pop2: got done=%b mode=%0d fifo=%0d want 0/0/0", done, mode, fifo_count); end
    tick();
    n_cmp++; if (mode !== 32'd10 || num_packets !== 32'd1 || busy !== 1'b1) begin n_err++; $display("FAIL zero_second: got mode=%0d np=%0d busy=%b want 10/1/1", mode, num_packets, busy); end
    beat();
    n_cmp++; if (done !== 1'b1 || pkt_count !== 16'd1) begin n_err++; $display("FAIL zero_second_done: got done=%b pkt=%0d want 1/1", done, pkt_count); end
    wait_idle("zero");
    $display("test_zero_packet complete");
  endtask

  task automatic test_abort_last();
    push(6'd11, 16'd1);
    tick(); tick();
    n_cmp++; if (mode !== 32'd11) begin n_err++; $display("FAIL abl_load: got mode=%0d want 11", mode); end
    abort = 1'b1;
    beat();
    abort = 1'b0;
    n_cmp++; if (aborted !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL abl_pulse: got aborted=%b done=%b want 1/0", aborted, done); end
    n_cmp++; if (mode !== 32'd0 || busy !== 1'b0) begin n_err++; $display("FAIL abl_state: got mode=%0d busy=%b want 0/0", mode, busy); end
    tick();
    n_cmp++; if (done !== 1'b0 || aborted !== 1'b0) begin n_err++; $display("FAIL abl_after: got done=%b aborted=%b want 0/0", done, aborted); end
    $display("test_abort_last complete");
  endtask

  task automatic test_back_to_back_gap0();
    push_g0(6'd12, 16'd1);
    push_g0(6'd13, 16'd2);
    n_cmp++; if (fifo_count_g0 !== 3'd1) begin n_err++; $display("FAIL g0_queue: got fifo=%0d want 1", fifo_count_g0); end
    tick();
    n_cmp++; if (mode_g0 !== 32'd12 || busy_g0 !== 1'b1) begin n_err++; $display("FAIL g0_first: got mode=%0d busy=%b want 12/1", mode_g0, busy_g0); end
    beat();
    n_cmp++; if (done_g0 !== 1'b1 || mode_g0 !== 32'd0 || busy_g0 !== 1'b0) begin n_err++; $display("FAIL g0_done: got done=%b mode=%0d busy=%b want 1/0/0", done_g0, mode_g0, busy_g0); end
    tick();
    n_cmp++; if (mode_g0 !== 32'd13 || num_packets_g0 !== 32'd2 || busy_g0 !== 1'b1) begin n_err++; $display("FAIL g0_second: got mode=%0d np=%0d busy=%b want 13/2/1", mode_g0, num_packets_g0, busy_g0); end
    n_cmp++; if (done_g0 !== 1'b0 || pkt_count_g0 !== 16'd0 || fifo_count_g0 !== 3'd0) begin n_err++; $display("FAIL g0_second_state: got done=%b pkt=%0d fifo=%0d want 0/0/0", done_g0, pkt_count_g0, fifo_count_g0); end
    beat(); beat();
    n_cmp++; if (done_g0 !== 1'b1 || pkt_count_g0 !== 16'd2 || busy_g0 !== 1'b0) begin n_err++; $display("FAIL g0_second_done: got done=%b pkt=%0d busy=%b want 1/2/0", done_g0, pkt_count_g0, busy_g0); end
    tick();
    $display("test_back_to_back_gap0 complete");
  endtask

  task automatic test_reset_mid();
    push(6'd14, 16'd3);
    tick(); tick();
    beat();
    push(6'd15, 16'd1);
    n_cmp++; if (mode !== 32'd14 || fifo_count !== 3'd1 || pkt_count !== 16'd1) begin n_err++; $display("FAIL rmid_pre: got mode=%0d fifo=%0d pkt=%0d want 14/1/1", mode, fifo_count, pkt_count); end
    rst = 1'b0;
    tick();
    #1;
    n_cmp++; if (mode !== 32'd0 || fifo_count !== 3'd0 || busy !== 1'b0 || pkt_count !== 16'd0) begin n_err++; $display("FAIL rmid_state: got mode=%0d fifo=%0d busy=%b pkt=%0d want 0/0/0/0", mode, fifo_count, busy, pkt_count); end
    n_cmp++; if (aborted !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL rmid_flags: got aborted=%b done=%b ready=%b want 0/0/0", aborted, done, cmd_ready); end
    rst = 1'b1;
    tick();
    $display("test_reset_mid complete");
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_valid_g0 = 1'b0; abort = 1'b0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    set_cmd(6'd0, 16'd0, 16'd0, 8'd0, 16'd0, 16'd0);
    test_reset();
    test_single();
    test_ignored_beats_and_abort();
    test_queue_full();
    test_zero_packet();
    test_abort_last();
    test_back_to_back_gap0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
